// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Optional build macro used by the receiver: UART_RX_MAJORITY_EN.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam logic [5:0] PRESC_8  = 6'd8;
   localparam logic [5:0] PRESC_16 = 6'd16;
   localparam logic [5:0] PRESC_32 = 6'd32;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Parallel result bus of the UART receiver.
// master drives the word and the result pulses, slave consumes them.
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_ERR;
   logic                  STP_ERR;

   modport master (output P_DATA, output DATA_VALID,
                   output PAR_ERR, output STP_ERR);
   modport slave  (input P_DATA, input DATA_VALID,
                   input PAR_ERR, input STP_ERR);
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit-timing counter and sample-point logic of the UART receiver.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around mid-bit.
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       i_line,
   input  logic       i_run,
   input  logic [5:0] i_presc,
   output logic       o_sampled_bit,
   output logic       o_sample_strobe,
   output logic       o_bit_end
);

   logic [5:0] r_edge_cnt;
   logic [5:0] w_half;

   assign w_half    = {1'b0, i_presc[5:1]};
   assign o_bit_end = i_run && (r_edge_cnt == i_presc - 6'd1);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_edge_cnt <= '0;
      end else if (!i_run || o_bit_end) begin
         r_edge_cnt <= '0;
      end else begin
         r_edge_cnt <= r_edge_cnt + 6'd1;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic r_s0;
   logic r_s1;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_s0 <= 1'b1;
         r_s1 <= 1'b1;
      end else begin
         if (r_edge_cnt == w_half - 6'd1) r_s0 <= i_line;
         if (r_edge_cnt == w_half)        r_s1 <= i_line;
      end
   end

   // vote completes one tick after mid-bit, still well before bit_end
   assign o_sample_strobe = i_run && (r_edge_cnt == w_half + 6'd1);
   assign o_sampled_bit   = maj3(r_s0, r_s1, i_line);
`else
   assign o_sample_strobe = i_run && (r_edge_cnt == w_half);
   assign o_sampled_bit   = i_line;
`endif

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: sync, frame FSM, parity/stop checks.
// Define UART_RX_MAJORITY_EN for 3-sample majority bit decisions.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic [5:0] Prescale,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   uart_rx_if.master  o_bus
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [2:0] S_IDLE   = IDLE;
   localparam logic [2:0] S_START  = START;
   localparam logic [2:0] S_DATA   = DATA;
   localparam logic [2:0] S_PARITY = PARITY;
   localparam logic [2:0] S_STOP   = STOP;

   logic [1:0]            r_sync;
   logic [2:0]            r_state;
   logic [CW-1:0]         r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_data;
   logic [5:0]            r_presc;
   logic                  r_pen;
   logic                  r_ptyp;
   logic                  r_false;
   logic                  r_perr;
   logic                  r_serr;
   logic                  r_valid;
   logic                  r_perr_o;
   logic                  r_serr_o;

   logic w_line;
   logic w_run;
   logic w_bit;
   logic w_strobe;
   logic w_bit_end;

   assign w_line = r_sync[1];
   assign w_run  = (r_state != S_IDLE) || !w_line;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_sync <= 2'b11;
      else      r_sync <= {r_sync[0], RX_IN};
   end

   uart_rx_sampler u_sampler (
      .CLK             (CLK),
      .RST             (RST),
      .i_line          (w_line),
      .i_run           (w_run),
      .i_presc         (r_presc),
      .o_sampled_bit   (w_bit),
      .o_sample_strobe (w_strobe),
      .o_bit_end       (w_bit_end)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_presc   <= PRESC_8;
         r_pen     <= 1'b0;
         r_ptyp    <= PAR_EVEN;
         r_false   <= 1'b0;
         r_perr    <= 1'b0;
         r_serr    <= 1'b0;
         r_valid   <= 1'b0;
         r_perr_o  <= 1'b0;
         r_serr_o  <= 1'b0;
      end else begin
         r_valid  <= 1'b0;
         r_perr_o <= 1'b0;
         r_serr_o <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_line) begin
                  r_state   <= S_START;
                  r_presc   <= Prescale;
                  r_pen     <= PAR_EN;
                  r_ptyp    <= PAR_TYP;
                  r_false   <= 1'b0;
                  r_perr    <= 1'b0;
                  r_serr    <= 1'b0;
                  r_bit_cnt <= '0;
               end
            end
            S_START: begin
               if (w_strobe) r_false <= w_bit;
               if (w_bit_end) r_state <= r_false ? S_IDLE : S_DATA;
            end
            S_DATA: begin
               if (w_strobe) r_shift[r_bit_cnt] <= w_bit;
               if (w_bit_end) begin
                  if (r_bit_cnt == CW'(DATA_WIDTH - 1))
                     r_state <= r_pen ? S_PARITY : S_STOP;
                  else
                     r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (w_strobe)
                  r_perr <= w_bit ^ (^r_shift) ^ (r_ptyp == PAR_ODD);
               if (w_bit_end) r_state <= S_STOP;
            end
            S_STOP: begin
               if (w_strobe) r_serr <= !w_bit;
               if (w_bit_end) begin
                  r_state  <= S_IDLE;
                  r_valid  <= !r_perr && !r_serr;
                  r_perr_o <= r_perr;
                  r_serr_o <= r_serr;
                  if (!r_perr && !r_serr) r_data <= r_shift;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_bus.P_DATA     = r_data;
   assign o_bus.DATA_VALID = r_valid;
   assign o_bus.PAR_ERR    = r_perr_o;
   assign o_bus.STP_ERR    = r_serr_o;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: randomized frames against a frame-level model.
// Glitch rejection is exercised only when UART_RX_MAJORITY_EN is defined.
module tb_uart_rx;

   typedef struct {
      logic       v;
      logic       pe;
      logic       se;
      logic [7:0] d;
      int         t;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [5:0] presc;
   logic       pen;
   logic       ptyp;

   int         cyc;
   int         errors;
   int         checks;
   logic [7:0] last_good;
   exp_t       q[$];

   uart_rx_if #(.DATA_WIDTH(8)) bus ();

   uart_rx #(.DATA_WIDTH(8)) dut (
      .CLK      (clk),
      .RST      (rst_n),
      .RX_IN    (rx),
      .Prescale (presc),
      .PAR_EN   (pen),
      .PAR_TYP  (ptyp),
      .o_bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  n, act, act, exp, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
         if (q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("data_valid", int'(bus.DATA_VALID), int'(e.v));
            chk("par_err", int'(bus.PAR_ERR), int'(e.pe));
            chk("stp_err", int'(bus.STP_ERR), int'(e.se));
            chk("p_data", int'(bus.P_DATA), int'(e.d));
            chk("latency", cyc, e.t);
         end
      end
   end

   // abort_at > 0 stops driving after that many cycles and expects nothing
   task automatic send(input logic [7:0] d, input int p, input bit pe,
                       input bit pt, input bit pbad, input bit sbad,
                       input int gbit, input int abort_at);
      logic fr[$];
      exp_t e;
      int   k;
      fr = {};
      fr.push_back(1'b0);
      for (int i = 0; i < 8; i++) fr.push_back(d[i]);
      if (pe) fr.push_back((^d) ^ pt ^ pbad);
      fr.push_back(!sbad);
      e.pe = pe && pbad;
      e.se = sbad;
      e.v  = !e.pe && !e.se;
      e.d  = e.v ? d : last_good;
      k = 0;
      for (int b = 0; b < fr.size(); b++) begin
         for (int c = 0; c < p; c++) begin
            @(posedge clk);
            #1;
            if (abort_at > 0 && k == abort_at) return;
            if (k == 0) begin
               presc = 6'(p);
               pen   = pe;
               ptyp  = pt;
               if (abort_at == 0) begin
                  e.t = cyc + fr.size() * p + 2;
                  q.push_back(e);
                  if (e.v) last_good = d;
               end
            end
            rx = fr[b] ^ (b == gbit && c == p / 2);
            k++;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         rx = 1'b1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 4000) begin
         @(posedge clk);
         n++;
      end
      chk("drain_timeout", q.size(), 0);
      idle(4);
   endtask

   initial begin
      int p;
      errors    = 0;
      checks    = 0;
      last_good = 8'h00;
      rst_n = 1'b0;
      rx    = 1'b1;
      presc = 6'd8;
      pen   = 1'b0;
      ptyp  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_p_data", int'(bus.P_DATA), 0);
      chk("rst_valid", int'(bus.DATA_VALID), 0);
      chk("rst_par_err", int'(bus.PAR_ERR), 0);
      chk("rst_stp_err", int'(bus.STP_ERR), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(4);

      send(8'hA5, 8, 0, 0, 0, 0, -1, 0);
      idle(3);
      send(8'h37, 16, 1, 0, 0, 0, -1, 0);
      idle(2);
      send(8'h37, 16, 1, 0, 1, 0, -1, 0);
      idle(2);
      send(8'h5A, 16, 0, 0, 0, 1, -1, 0);
      idle(2);
      drain();

      presc = 6'd16;
      repeat (3) begin
         @(posedge clk);
         #1;
         rx = 1'b0;
      end
      idle(60);
      chk("false_start_quiet", q.size(), 0);

      send(8'h00, 32, 1, 1, 0, 0, -1, 0);
      send(8'hFF, 32, 1, 1, 0, 0, -1, 0);
      idle(2);
      drain();

      send(8'h6B, 8, 0, 0, 0, 0, -1, 4 * 8 + 4);
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("midrst_p_data", int'(bus.P_DATA), 0);
      chk("midrst_valid", int'(bus.DATA_VALID), 0);
      chk("midrst_errs", int'(bus.PAR_ERR | bus.STP_ERR), 0);
      last_good = 8'h00;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);
      send(8'hC3, 8, 0, 0, 0, 0, -1, 0);
      idle(2);
      drain();

`ifdef UART_RX_MAJORITY_EN
      send(8'h81, 16, 0, 0, 0, 0, 4, 0);
      idle(2);
      send(8'h81, 8, 1, 0, 0, 0, 1, 0);
      idle(2);
      drain();
`endif

      for (int i = 0; i < 16; i++) begin
         bit pe_r;
         case ($urandom % 3)
            0:       p = 8;
            1:       p = 16;
            default: p = 32;
         endcase
         pe_r = 1'($urandom % 2);
         send(8'($urandom), p, pe_r, 1'($urandom % 2),
              pe_r && ($urandom % 4 == 0), ($urandom % 6 == 0), -1, 0);
         idle(int'($urandom % 3));
      end
      idle(2);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive-side counterpart of the team's UART transmitter. It shares the same frame format: one start bit (0), DATA_WIDTH data bits sent LSB first, an optional parity bit, and one stop bit (1). The block oversamples the serial line at a programmable rate, checks the parity and stop bits, and presents each frame as a parallel word. It sits between the pad-side RX line and the system's parallel consumer.

## Interface
- DATA_WIDTH, 8, number of data bits per frame
- CLK  input  1  oversampling clock; one clock, Prescale ticks per bit
- RST  input  1  asynchronous, active-low reset
- RX_IN  input  1  serial line, idle high, asynchronous to CLK
- Prescale  input  6  oversampling ratio; legal values are 8, 16 and 32
- PAR_EN  input  1  1 means a parity bit is present after the data bits
- PAR_TYP  input  1  0 selects even parity, 1 selects odd parity
- P_DATA  output  DATA_WIDTH  last good received word
- DATA_VALID  output  1  one-cycle pulse when P_DATA is updated
- PAR_ERR  output  1  one-cycle pulse on a parity mismatch
- STP_ERR  output  1  one-cycle pulse when the stop bit samples 0

## Operation
- RX_IN passes through a 2-flop synchronizer (reset value 1). All behaviour below refers to the synchronized line.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the line is 0, go to START. The detection cycle counts as tick 0. Latch Prescale, PAR_EN and PAR_TYP here; they hold for the rest of the frame.
  - Each bit lasts Prescale ticks. edge_cnt runs 0..Prescale-1 and wraps to 0 at each bit boundary. bit_cnt counts data bits.
  - START: if the sampled value is 1, the start was a false start; return to IDLE at the end of that bit with no outputs asserted. Otherwise go to DATA.
  - DATA: shift the sample into bit position bit_cnt (LSB first). After DATA_WIDTH bits, go to PARITY if PAR_EN is set, otherwise to STOP.
  - PARITY: the expected bit is the XOR of the data bits, inverted when PAR_TYP=1. A mismatch sets an internal error flag.
  - STOP: the expected sample is 1. On the last tick, evaluate the frame and return to IDLE.
- Frame result (registered, asserted on the cycle after the last stop tick):
  - No error: DATA_VALID=1 and P_DATA is loaded with the received word.
  - Parity error: PAR_ERR=1. DATA_VALID stays 0 and P_DATA keeps its previous value.
  - Stop error: STP_ERR=1 with the same suppression. Both error pulses may occur together.
- A new start bit is accepted on the first IDLE cycle, so back-to-back frames need no idle gap.
- Reset: P_DATA=0 and DATA_VALID, PAR_ERR, STP_ERR all 0. State returns to IDLE and all counters clear. Reset mid-frame discards the partial frame.
- Prescale values other than 8, 16 and 32 give undefined results. The block takes no action on them.

## Timing
- Sample point: edge_cnt == Prescale/2 (the single-sample case).
- Frame length: N = 1 + DATA_WIDTH + PAR_EN + 1 bits.
- Latency: the result pulse occurs N*Prescale + 2 cycles after the RX_IN falling edge. The +2 is the synchronizer delay.
- All outputs are registered, and every pulse is exactly one cycle wide.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit is a 2-of-3 majority vote of samples at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. A single-cycle glitch at mid-bit is rejected.
- Macro undefined: one sample per bit at edge_cnt = Prescale/2. The sampler has no vote logic and a glitch at that tick corrupts the bit.
- Latency and all other behaviour are identical in both builds.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the parity-type constants PAR_EVEN=0 and PAR_ODD=1;
  - the legal Prescale constants.
- Sub-module uart_rx_sampler holds the edge counter, the sample-point decode and the sampling logic (majority vote when the macro is defined). It outputs sampled_bit, sample_strobe and bit_end to the FSM.

## Test plan
- Basic frame: Prescale=8, PAR_EN=0, send 0xA5 → one DATA_VALID pulse 82 cycles after the falling edge, P_DATA=0xA5, no error pulses.
- Even parity good: Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x37 with parity bit 1 → DATA_VALID, P_DATA=0x37.
- Parity error: repeat the previous frame with parity bit 0 → PAR_ERR pulse, no DATA_VALID, P_DATA still 0x37.
- Stop error and false start:
  - Drive stop bit 0 on frame 0x5A → STP_ERR pulse only.
  - Drive RX_IN low for 3 cycles at Prescale=16 → no output pulses, FSM back in IDLE.
- Back-to-back: Prescale=32, PAR_EN=1, PAR_TYP=1, send 0x00 then 0xFF with no gap → two DATA_VALID pulses 11*32 cycles apart, with P_DATA=0x00 then 0xFF.
- Reset and glitch:
  - Assert RST during DATA bit 3 → all outputs 0 and FSM in IDLE; the next frame 0xC3 is received correctly.
  - With UART_RX_MAJORITY_EN defined, a 1-cycle inversion at mid-bit of frame 0x81 → P_DATA=0x81.
